// File: rtl/hdmi_audio_pacer_pkg.sv
// Shared constants and types for the HDMI audio pacer.
package hdmi_audio_pkg;

    localparam int MHZ             = 1_000_000;
    localparam int DEF_SAMPLE_RATE = 192_000;

    // 29 bits covers a 255 MHz divisor plus the increment with headroom.
    localparam int ACC_W = 29;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } pacer_state_e;

    // Pixel-clock frequency in MHz to the divisor in Hz.
    function automatic logic [ACC_W-1:0] mhz_to_div(input logic [ACC_W-1:0] mhz);
        return mhz * ACC_W'(MHZ);
    endfunction

endpackage

// File: rtl/hdmi_audio_pacer_if.sv
// Audio-side bundle between the pacer and its environment.
interface hdmi_audio_pacer_if #(
    parameter int CHANNELS = 2,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 24,
    parameter int FREQ_W   = 8
);
    logic                      locked;
    logic [FREQ_W-1:0]         freq;
    logic                      mute;
    logic [CHANNELS*IN_W-1:0]  audio_in;
    logic [CHANNELS*OUT_W-1:0] audio_out;
    logic                      audio_clk;
    logic                      sample_stb;
    logic                      running;

    modport master (
        output locked, freq, mute, audio_in,
        input  audio_out, audio_clk, sample_stb, running
    );

    modport slave (
        input  locked, freq, mute, audio_in,
        output audio_out, audio_clk, sample_stb, running
    );
endinterface

// File: rtl/hdmi_audio_pacer_frac_rate_gen.sv
// Bresenham phase accumulator producing an exact-average square wave.
// The output toggles whenever the accumulated increment crosses the divisor,
// so toggle spacing is always floor or ceil of div/inc.
module frac_rate_gen
    import hdmi_audio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] div,
    input  logic [ACC_W-1:0] inc,
    output logic             tgl_o,
    output logic             fall_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum_s;
    logic             hit_s;
    logic             tgl_q;
    logic             tgl_d;

    assign sum_s = acc_q + inc;
    assign hit_s = (sum_s >= div);

    // Next accumulator/toggle value: clear wins over advance.
    always_comb begin
        acc_d = acc_q;
        tgl_d = tgl_q;
        if (clr) begin
            acc_d = '0;
            tgl_d = 1'b0;
        end else if (en) begin
            if (hit_s) begin
                acc_d = sum_s - div;
                tgl_d = ~tgl_q;
            end else begin
                acc_d = sum_s;
                tgl_d = tgl_q;
            end
        end else begin
            acc_d = acc_q;
            tgl_d = tgl_q;
        end
    end

    // Accumulator and toggle registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            tgl_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            tgl_q <= tgl_d;
        end
    end

    // High in the cycle whose closing edge takes the output from 1 to 0.
    assign fall_o = en & ~clr & hit_s & tgl_q;
    assign tgl_o  = tgl_q;

endmodule

// File: rtl/hdmi_audio_pacer.sv
// Audio sample pacer: derives an exact-average SAMPLE_RATE clock from the
// runtime pixel-clock frequency, captures and left-aligns the samples on each
// falling audio_clk edge, and handles mute and PLL lock loss.
// IN_W must not exceed OUT_W.
module hdmi_audio_pacer
    import hdmi_audio_pkg::*;
#(
    parameter int SAMPLE_RATE = DEF_SAMPLE_RATE,
    parameter int CHANNELS    = 2,
    parameter int IN_W        = 16,
    parameter int OUT_W       = 24,
    parameter int FREQ_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    hdmi_audio_pacer_if.slave  bus
);

    localparam int               SHIFT = OUT_W - IN_W;
    localparam logic [ACC_W-1:0] INC   = ACC_W'(2 * SAMPLE_RATE);

    pacer_state_e              state_q;
    pacer_state_e              state_d;
    logic [FREQ_W-1:0]         freq_q;
    logic [ACC_W-1:0]          div_q;
    logic                      load_s;
    logic                      en_s;
    logic                      clr_s;
    logic                      tgl_s;
    logic                      fall_s;
    logic [CHANNELS*OUT_W-1:0] cap_s;
    logic [CHANNELS*OUT_W-1:0] audio_out_q;
    logic                      stb_q;
    logic                      running_q;

    // Next state and rate-generator control; lock/frequency loss beats reload.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        en_s    = 1'b0;
        clr_s   = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.locked && (bus.freq != '0)) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                load_s  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (!bus.locked || (bus.freq == '0)) begin
                    state_d = IDLE;
                end else if (bus.freq != freq_q) begin
                    state_d = LOAD;
                end else begin
                    state_d = RUN;
                    en_s    = 1'b1;
                    clr_s   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frequency and divisor latched only in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            freq_q <= '0;
            div_q  <= '0;
        end else if (load_s) begin
            freq_q <= bus.freq;
            div_q  <= mhz_to_div(ACC_W'(bus.freq));
        end else begin
            freq_q <= freq_q;
            div_q  <= div_q;
        end
    end

    frac_rate_gen u_rate (
        .clk    (clk),
        .reset  (reset),
        .en     (en_s),
        .clr    (clr_s),
        .div    (div_q),
        .inc    (INC),
        .tgl_o  (tgl_s),
        .fall_o (fall_s)
    );

    // Left-align every channel into the wider output slot.
    always_comb begin
        cap_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cap_s[c*OUT_W +: OUT_W] = OUT_W'(bus.audio_in[c*IN_W +: IN_W]) << SHIFT;
        end
    end

    // Sample capture on the falling audio_clk edge, strobe and run flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            audio_out_q <= '0;
            stb_q       <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            running_q <= (state_d == RUN);
            stb_q     <= fall_s;
            if (fall_s) begin
                audio_out_q <= bus.mute ? '0 : cap_s;
            end else begin
                audio_out_q <= audio_out_q;
            end
        end
    end

    assign bus.audio_out  = audio_out_q;
    assign bus.audio_clk  = tgl_s;
    assign bus.sample_stb = stb_q;
    assign bus.running    = running_q;

endmodule

// File: tb/tb_hdmi_audio_pacer.sv
// Directed bench for hdmi_audio_pacer with a cycle-level reference model.
module tb_hdmi_audio_pacer;

    localparam int     CH     = 2;
    localparam int     IN_W   = 16;
    localparam int     OUT_W  = 24;
    localparam int     FREQ_W = 8;
    localparam int     SR     = 192000;
    localparam longint INC    = 2 * SR;

    logic clk = 1'b0;
    logic reset;

    hdmi_audio_pacer_if #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .FREQ_W(FREQ_W)) bus ();

    hdmi_audio_pacer #(
        .SAMPLE_RATE(SR), .CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .FREQ_W(FREQ_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;
    longint stb_t[$];
    longint tgl_t[$];
    longint run_rise    = -1;

    // Reference model state
    int                   ms;
    longint               mfq;
    longint               mn;
    logic                 mclk;
    logic                 mstb;
    logic                 mrun;
    logic [CH*OUT_W-1:0]  mout;
    bit                   mvalid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_in(input string name, input longint act, input longint lo, input longint hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_stb(input int n, input int budget);
        for (int i = 0; i < budget && stb_t.size() < n; i++) nstep();
        chk("strobe_wait", 64'(stb_t.size() >= n), 64'd1);
    endtask

    task automatic wait_clk_high(input int budget);
        for (int i = 0; i < budget && bus.audio_clk !== 1'b1; i++) nstep();
        chk("wait_clk_high", 64'(bus.audio_clk), 64'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: toggle count since entering RUN is floor(n*INC/DIV); a strobe is
    // the step of that count onto an even value.
    initial begin
        longint dv, k, kp;
        forever begin
            @(posedge clk);
            if (reset) begin
                ms = 0; mfq = 0; mn = 0; mclk = 1'b0; mstb = 1'b0; mrun = 1'b0; mout = '0;
            end else begin
                mstb = 1'b0;
                case (ms)
                    0: begin
                        mclk = 1'b0;
                        if (bus.locked && bus.freq != 0) ms = 1;
                    end
                    1: begin
                        mfq = longint'(bus.freq); mn = 0; mclk = 1'b0; ms = 2;
                    end
                    default: begin
                        if (!bus.locked || bus.freq == 0) begin
                            ms = 0; mclk = 1'b0;
                        end else if (longint'(bus.freq) != mfq) begin
                            ms = 1; mclk = 1'b0;
                        end else begin
                            mn++;
                            dv = mfq * 1_000_000;
                            k  = (mn * INC) / dv;
                            kp = ((mn - 1) * INC) / dv;
                            mclk = k[0];
                            if (k != kp && k[0] == 1'b0) begin
                                mstb = 1'b1;
                                for (int c = 0; c < CH; c++) begin
                                    mout[c*OUT_W +: OUT_W] = bus.mute ? '0 :
                                        OUT_W'(longint'(bus.audio_in[c*IN_W +: IN_W]) * (longint'(1) << (OUT_W - IN_W)));
                                end
                            end
                        end
                    end
                endcase
                mrun = (ms == 2);
            end
            mvalid = 1'b1;
        end
    end

    // Monitor and per-cycle comparison against the model.
    initial begin
        logic prev_clk = 1'b0;
        logic prev_run = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.sample_stb === 1'b1) stb_t.push_back(cyc);
            if (bus.audio_clk !== prev_clk) tgl_t.push_back(cyc);
            if (bus.running === 1'b1 && prev_run !== 1'b1) run_rise = cyc;
            prev_clk = bus.audio_clk;
            prev_run = bus.running;
            if (mvalid) begin
                chk("model_audio_clk",  64'(bus.audio_clk),  64'(mclk));
                chk("model_sample_stb", 64'(bus.sample_stb), 64'(mstb));
                chk("model_running",    64'(bus.running),    64'(mrun));
                chk("model_audio_out",  64'(bus.audio_out),  64'(mout));
            end
        end
    end

    initial begin
        int                  n0;
        int                  cnt;
        logic [CH*OUT_W-1:0] held;

        reset = 1'b1; bus.locked = 1'b0; bus.freq = 8'd0; bus.mute = 1'b0; bus.audio_in = '0;
        repeat (3) nstep();
        chk("rst_audio_out", 64'(bus.audio_out),  64'd0);
        chk("rst_audio_clk", 64'(bus.audio_clk),  64'd0);
        chk("rst_stb",       64'(bus.sample_stb), 64'd0);
        chk("rst_running",   64'(bus.running),    64'd0);

        // Locked but frequency unknown: must stay idle
        reset = 1'b0; bus.locked = 1'b1;
        repeat (300) nstep();
        chk("freq0_running", 64'(bus.running),   64'd0);
        chk("freq0_clk",     64'(bus.audio_clk), 64'd0);

        // 48 MHz: exact 125-cycle half periods, 250-cycle strobes
        bus.audio_in = {16'h7FFF, 16'h8000};
        stb_t.delete(); tgl_t.delete();
        bus.freq = 8'd48;
        wait_stb(3, 1000);
        chk("running_48", 64'(bus.running), 64'd1);
        if (stb_t.size() >= 3) begin
            chk("first_stb_48", 64'(stb_t[0] - run_rise), 64'd250);
            chk("gap_48_a",     64'(stb_t[1] - stb_t[0]), 64'd250);
            chk("gap_48_b",     64'(stb_t[2] - stb_t[1]), 64'd250);
        end
        if (tgl_t.size() >= 3) begin
            chk("half_48_a", 64'(tgl_t[1] - tgl_t[0]), 64'd125);
            chk("half_48_b", 64'(tgl_t[2] - tgl_t[1]), 64'd125);
        end
        chk("widen_48", 64'(bus.audio_out), 64'h7FFF00_800000);

        // Mute zeros the next capture
        bus.mute = 1'b1;
        n0 = stb_t.size();
        wait_stb(n0 + 1, 400);
        chk("mute_out", 64'(bus.audio_out), 64'd0);
        bus.mute = 1'b0;
        bus.audio_in = {16'h1234, 16'hFFFF};

        // Frequency change while audio_clk is high
        wait_clk_high(300);
        bus.freq = 8'd74;
        n0 = stb_t.size();
        nstep();
        chk("reload_clk_low",  64'(bus.audio_clk), 64'd0);
        chk("reload_running",  64'(bus.running),   64'd0);
        nstep();
        chk("reload_run_back", 64'(bus.running),   64'd1);
        chk("reload_no_stb",   64'(stb_t.size()),  64'(n0));

        // 74 MHz: 385/386-cycle strobes, 12 per 4625 cycles
        stb_t.delete();
        wait_stb(13, 6000);
        if (stb_t.size() >= 13) begin
            chk("first_stb_74", 64'(stb_t[0] - run_rise), 64'd386);
            for (int i = 1; i < 13; i++) chk_in("gap_74", stb_t[i] - stb_t[i-1], 385, 386);
            cnt = 0;
            foreach (stb_t[i]) if (stb_t[i] < stb_t[0] + 4625) cnt++;
            chk("window_74", 64'(cnt), 64'd12);
        end
        chk("widen_74", 64'(bus.audio_out), 64'h123400_FFFF00);

        // Lock loss for 10 cycles, then relock at 48 MHz
        held = bus.audio_out;
        bus.locked = 1'b0;
        nstep();
        chk("unlock_running", 64'(bus.running),   64'd0);
        chk("unlock_clk",     64'(bus.audio_clk), 64'd0);
        repeat (9) nstep();
        bus.freq = 8'd48;
        chk("unlock_held", 64'(bus.audio_out), 64'(held));
        stb_t.delete();
        bus.locked = 1'b1;
        wait_stb(1, 600);
        if (stb_t.size() >= 1) chk("relock_first_stb", 64'(stb_t[0] - run_rise), 64'd250);

        // Reset while audio_clk is high
        wait_clk_high(300);
        reset = 1'b1;
        nstep();
        chk("midrst_audio_out", 64'(bus.audio_out),  64'd0);
        chk("midrst_audio_clk", 64'(bus.audio_clk),  64'd0);
        chk("midrst_stb",       64'(bus.sample_stb), 64'd0);
        chk("midrst_running",   64'(bus.running),    64'd0);

        reset = 1'b0; bus.freq = 8'd0; bus.locked = 1'b1;
        repeat (500) nstep();
        chk("freq0_idle_running", 64'(bus.running),   64'd0);
        chk("freq0_idle_clk",     64'(bus.audio_clk), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
